// File: rtl/stdout_mmio.sv
// stdout_mmio: CPU store decode into a small FIFO drained to the stdout sink.
// Optional pacing gap between sink pulses, CPU stall on full, status register.
module stdout_mmio #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] DATA_ADDR = 32'h0000_00FF,
    parameter logic [31:0] STAT_ADDR = 32'h0000_00FE,
    parameter int unsigned DRAIN_GAP = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        write_o,
    output logic [31:0] dout_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    state_t        state_q, state_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic [15:0]   emitted_q, emitted_d;
    logic          write_q, write_d;
    logic [31:0]   dout_q, dout_d;

    logic          full, empty, hit_data, push, pop, busy;
    logic [7:0]    level8;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign hit_data = we_i && (addr_i == DATA_ADDR);
    assign push     = hit_data && !full;
    assign stall_o  = hit_data && full;
    assign busy     = !empty || (state_q != IDLE) || write_q;
    assign write_o  = write_q;
    assign dout_o   = dout_q;

    // Drain FSM: pop head into the sink, then optionally sit out the gap
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        write_d   = 1'b0;
        dout_d    = dout_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    write_d = 1'b1;
                    dout_d  = mem_q[rd_ptr_q];
                    if (DRAIN_GAP != 0) begin
                        state_d   = GAP;
                        gap_cnt_d = 8'(DRAIN_GAP);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd1) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
        endcase
    end

    // FIFO pointers, fill level and emitted-word counter
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        emitted_d = emitted_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            emitted_d = emitted_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Status word readback; zero for any other address or no load
    always_comb begin
        level8           = '0;
        level8[LW-1:0]   = level_q;
        rdata_o          = '0;
        if (re_i && (addr_i == STAT_ADDR)) begin
            rdata_o = {emitted_q, 5'b0, busy, full, empty, level8};
        end
    end

    // FIFO storage; contents are dead once the level says so
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            emitted_q <= '0;
            write_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            emitted_q <= emitted_d;
            write_q   <= write_d;
            dout_q    <= dout_d;
        end
    end
endmodule
